tag_allocator: RTL and testbench

- Owns a pool of NUM_TAGS tags (load-queue/ROB-style slot IDs). Hands out up to NUM_ALLOC tags per cycle, lowest free index first, using first-N-set-bits priority search over a free bitmap.
- Accepts up to NUM_FREE returned tags per cycle. Each returned tag index is decoded one-hot back into the bitmap.
- Sits between rename/dispatch, which allocates, and the completion/commit path, which frees.

---
 rtl/tag_allocator.sv | 161 ++++++++++++++++
 tb/tb_tag_allocator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tag_allocator.sv
// -----------------------------------------------------------------------------
// tag_allocator
//
// Keeps a pool of NUM_TAGS slot IDs (load-queue / ROB style). Each tag is one
// bit in a free bitmap. Every cycle the block offers up to NUM_ALLOC tags, with
// the lowest free index first. It also takes back up to NUM_FREE returned tags.
// Rename/dispatch allocates and the completion/commit path frees.
//
// Offers and the free count are computed only from the registered bitmap.
// A tag that is returned this cycle is therefore offered one cycle later, and
// the free path stays off the bitmap -> offer critical path.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active high
//   IN_flush       return every tag to the pool (overrides allocs and frees)
//   IN_allocReq    per-port allocation request
//   OUT_tag        per-port offered tag (0 when no tag is offered)
//   OUT_tagValid   per-port "offered tag exists"
//   IN_freeValid   per-port free valid
//   IN_freeTag     per-port returned tag index
//   OUT_freeCount  number of currently free tags
//   OUT_error      sticky bad-free flag
//
// Optional feature: define TAG_ALLOC_DOUBLE_FREE_CHECK_EN to enable bad-free
// detection. A bad free is a free of an already-free tag, of an out-of-range
// tag, or of a tag that appears twice in one cycle. When detected, OUT_error
// is set the next cycle and stays set until rst. Without the macro,
// OUT_error is tied to 0.
// -----------------------------------------------------------------------------
module tag_allocator #(
  parameter  int NUM_TAGS  = 32,
  parameter  int NUM_ALLOC = 2,
  parameter  int NUM_FREE  = 2,
  localparam int TAG_W     = $clog2(NUM_TAGS),
  localparam int CNT_W     = $clog2(NUM_TAGS + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            IN_flush,
  input  logic [NUM_ALLOC-1:0]            IN_allocReq,
  output logic [NUM_ALLOC-1:0][TAG_W-1:0] OUT_tag,
  output logic [NUM_ALLOC-1:0]            OUT_tagValid,
  input  logic [NUM_FREE-1:0]             IN_freeValid,
  input  logic [NUM_FREE-1:0][TAG_W-1:0]  IN_freeTag,
  output logic [CNT_W-1:0]                OUT_freeCount,
  output logic                            OUT_error
);

  logic [NUM_TAGS-1:0] free_q;
  logic [NUM_TAGS-1:0] alloc_mask;
  logic [NUM_TAGS-1:0] free_mask;
  logic [NUM_TAGS-1:0] search_mask;

  // Cascaded masked priority encoders. Port i sees the bitmap with the tags
  // of ports 0..i-1 removed, so it picks the (i+1)-th lowest free tag.
  // NOTE: every signal written in always_comb gets a default at the top of the
  // block, so no path can leave it unassigned and no latch is inferred.
  always_comb begin
    search_mask  = free_q;
    OUT_tag      = '0;
    OUT_tagValid = '0;
    for (int i = 0; i < NUM_ALLOC; i++) begin
      // Scan downward so the last hit, which is the lowest index, wins.
      for (int k = NUM_TAGS - 1; k >= 0; k--) begin
        if (search_mask[k]) begin
          OUT_tag[i]      = TAG_W'(k);
          OUT_tagValid[i] = 1'b1;
        end
      end
      if (OUT_tagValid[i]) search_mask[OUT_tag[i]] = 1'b0;
    end
  end

  // Only a port that both requests and has a valid offer takes its tag. A
  // port can be granted even when a lower-numbered port does not request.
  always_comb begin
    alloc_mask = '0;
    for (int i = 0; i < NUM_ALLOC; i++) begin
      if (IN_allocReq[i] && OUT_tagValid[i]) alloc_mask[OUT_tag[i]] = 1'b1;
    end
  end

  // Returned tags are decoded one-hot and OR'd together, so a duplicate index
  // is harmless. Indices beyond the pool are dropped.
  always_comb begin
    free_mask = '0;
    for (int j = 0; j < NUM_FREE; j++) begin
      if (IN_freeValid[j] && (int'(IN_freeTag[j]) < NUM_TAGS))
        free_mask[IN_freeTag[j]] = 1'b1;
    end
  end

  always_comb begin
    OUT_freeCount = '0;
    for (int k = 0; k < NUM_TAGS; k++) OUT_freeCount = OUT_freeCount + CNT_W'(free_q[k]);
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the clock edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_q <= '1;
    end else if (IN_flush) begin
      free_q <= '1;
    end else begin
      free_q <= (free_q & ~alloc_mask) | free_mask;
    end
  end

`ifdef TAG_ALLOC_DOUBLE_FREE_CHECK_EN
  logic             bad_free;
  logic [TAG_W-1:0] bad_tag;
  logic             error_q;

  // A free is bad if its index is out of range, if the tag is already free
  // in the current bitmap, or if an earlier port returns the same index in
  // this cycle.
  always_comb begin
    bad_free = 1'b0;
    bad_tag  = '0;
    for (int j = NUM_FREE - 1; j >= 0; j--) begin
      if (IN_freeValid[j]) begin
        if (int'(IN_freeTag[j]) >= NUM_TAGS) begin
          bad_free = 1'b1;
          bad_tag  = IN_freeTag[j];
        end else if (free_q[IN_freeTag[j]]) begin
          bad_free = 1'b1;
          bad_tag  = IN_freeTag[j];
        end
        for (int m = 0; m < j; m++) begin
          if (IN_freeValid[m] && (IN_freeTag[m] == IN_freeTag[j])) begin
            bad_free = 1'b1;
            bad_tag  = IN_freeTag[j];
          end
        end
      end
    end
  end

  // Sticky: only rst clears it; a flush leaves it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_q <= 1'b0;
    else if (bad_free) error_q <= 1'b1;
  end

  assign OUT_error = error_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!bad_free)
        else $error("tag_allocator: bad free of tag %0d", bad_tag);
    end
  end
`endif
`else
  assign OUT_error = 1'b0;
`endif

endmodule

// File: tb/tb_tag_allocator.sv
// -----------------------------------------------------------------------------
// tb_tag_allocator
//
// Directed testbench for tag_allocator with NUM_TAGS=32 and two allocation
// and two free ports. A table of per-cycle vectors gives the inputs for each
// cycle together with the outputs expected from the state at the start of
// that cycle. Hand-written sequences cover async reset in mid-operation,
// duplicate frees, and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_tag_allocator;

  localparam int NT = 32;
  localparam int NA = 2;
  localparam int NF = 2;
  localparam int TW = $clog2(NT);
  localparam int CW = $clog2(NT + 1);

`ifdef TAG_ALLOC_DOUBLE_FREE_CHECK_EN
  localparam bit DF_EN = 1'b1;
`else
  localparam bit DF_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     flush;
  logic [NA-1:0]            alloc_req;
  logic [NA-1:0][TW-1:0]    tag;
  logic [NA-1:0]            tag_valid;
  logic [NF-1:0]            free_valid;
  logic [NF-1:0][TW-1:0]    free_tag;
  logic [CW-1:0]            free_count;
  logic                     error;

  tag_allocator #(.NUM_TAGS(NT), .NUM_ALLOC(NA), .NUM_FREE(NF)) dut (
    .clk          (clk),
    .rst          (rst),
    .IN_flush     (flush),
    .IN_allocReq  (alloc_req),
    .OUT_tag      (tag),
    .OUT_tagValid (tag_valid),
    .IN_freeValid (free_valid),
    .IN_freeTag   (free_tag),
    .OUT_freeCount(free_count),
    .OUT_error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       flush;
    bit [1:0] req;
    bit [1:0] fv;
    int       ft0;
    int       ft1;
    int       tag0;
    int       tag1;
    bit [1:0] valid;
    int       count;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(bit fl, bit [1:0] rq, bit [1:0] fv, int ft0, int ft1,
                              int t0, int t1, bit [1:0] vl, int cnt);
    vec_t v;
    v.flush = fl; v.req = rq; v.fv = fv; v.ft0 = ft0; v.ft1 = ft1;
    v.tag0 = t0; v.tag1 = t1; v.valid = vl; v.count = cnt;
    vecs.push_back(v);
  endfunction

  task automatic drive(bit fl, bit [1:0] rq, bit [1:0] fv, int ft0, int ft1);
    flush       = fl;
    alloc_req   = rq;
    free_valid  = fv;
    free_tag[0] = TW'(ft0);
    free_tag[1] = TW'(ft1);
  endtask

  task automatic check_offer(string name, int t0, int t1, bit [1:0] vl, int cnt);
    check({name, ".tag0"},  32'(tag[0]),     32'(t0));
    check({name, ".tag1"},  32'(tag[1]),     32'(t1));
    check({name, ".valid"}, 32'(tag_valid),  32'(vl));
    check({name, ".count"}, 32'(free_count), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 2'b00, 2'b00, 0, 0);

    // Full pool: sixteen cycles of two grants each drain tags 0..31 in order.
    for (int k = 0; k < 16; k++) add(0, 2'b11, 2'b00, 0, 0, 2*k, 2*k+1, 2'b11, NT - 2*k);
    // Empty pool: requests are ignored; tags 7 and 3 are freed.
    add(0, 2'b11, 2'b11, 7, 3, 0, 0, 2'b00, 0);
    add(0, 2'b00, 2'b00, 0, 0, 3, 7, 2'b11, 2);
    add(0, 2'b11, 2'b00, 0, 0, 3, 7, 2'b11, 2);
    // Only tag 5 free: port 0 takes it, port 1 has no offer.
    add(0, 2'b00, 2'b01, 5, 0, 0, 0, 2'b00, 0);
    add(0, 2'b11, 2'b00, 0, 0, 5, 0, 2'b01, 1);
    // Allocate 0,1 while freeing 9,12 in the same cycle.
    add(0, 2'b00, 2'b11, 0, 1, 0, 0, 2'b00, 0);
    add(0, 2'b11, 2'b11, 9, 12, 0, 1, 2'b11, 2);
    // Non-contiguous requests: port 1 alone, then port 0 alone.
    add(0, 2'b10, 2'b00, 0, 0, 9, 12, 2'b11, 2);
    add(0, 2'b01, 2'b00, 0, 0, 9, 0, 2'b01, 1);
    // Flush from empty, then use half of the pool.
    add(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b00, 0);
    for (int k = 0; k < 8; k++) add(0, 2'b11, 2'b00, 0, 0, 2*k, 2*k+1, 2'b11, NT - 2*k);
    // Flush overrides a same-cycle alloc and free.
    add(1, 2'b11, 2'b01, 3, 0, 16, 17, 2'b11, 16);
    add(0, 2'b00, 2'b00, 0, 0, 0, 1, 2'b11, NT);

    // Combinational outputs while reset is held.
    #1;
    check_offer("reset", 0, 1, 2'b11, NT);
    check("reset.error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].flush, vecs[n].req, vecs[n].fv, vecs[n].ft0, vecs[n].ft1);
      #1;
      check_offer($sformatf("v%0d", n), vecs[n].tag0, vecs[n].tag1, vecs[n].valid, vecs[n].count);
      check($sformatf("v%0d.error", n), 32'(error), 32'd0);
    end

    // Reset in mid-operation: the bitmap refills with no clock edge, and
    // grants requested while reset is held are lost.
    @(negedge clk);
    drive(0, 2'b11, 2'b00, 0, 0);
    @(negedge clk);
    check("midrst.before", 32'(free_count), 32'd30);
    rst = 1'b1;
    #1;
    check_offer("midrst.async", 0, 1, 2'b11, NT);
    @(negedge clk);
    check("midrst.held", 32'(free_count), 32'(NT));
    rst = 1'b0;
    drive(0, 2'b00, 2'b00, 0, 0);

    // Duplicate free: allocate 0,1, then return tag 1 on both ports.
    @(negedge clk);
    drive(0, 2'b11, 2'b00, 0, 0);
    @(negedge clk);
    drive(0, 2'b00, 2'b11, 1, 1);
    @(negedge clk);
    drive(0, 2'b00, 2'b00, 0, 0);
    #1;
    check_offer("dupfree", 1, 2, 2'b11, NT - 1);
    check("dupfree.error", 32'(error), 32'(DF_EN));
    rst = 1'b1;
    #1;
    check("dupfree.rst_clears", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Double free of tag 4 while it is free; the flag survives a flush.
    @(negedge clk);
    drive(0, 2'b00, 2'b01, 4, 0);
    @(negedge clk);
    drive(1, 2'b00, 2'b00, 0, 0);
    #1;
    check("dblfree.count", 32'(free_count), 32'(NT));
    check("dblfree.error", 32'(error), 32'(DF_EN));
    @(negedge clk);
    drive(0, 2'b00, 2'b00, 0, 0);
    #1;
    check("dblfree.after_flush", 32'(error), 32'(DF_EN));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
